uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART transmitter between NREQ byte-stream requesters (CPU console, debug logger, ...).
//  Round-robin arbitration with per-message lock, so lines from different sources do not interleave.
//  Drives the UART's slave bus (stb/wea/dat) and polls its busy bit before every write.
//  Sits between the requesters and the UART, and is the only master on the UART bus.
// PARAMETERS
//  NREQ         2         number of requesters, 1..8
//  DEFAULT_RATE 24'h00C9  baud increment (baud*2^24/f_clk), used when rate_i == 0
//  LOCK_TIMEOUT 1023      idle cycles of the lock owner before the lock is dropped
// PORTS
//  sys_clk_i    in   1       system clock
//  sys_rst_i    in   1       synchronous, active-high reset
//  req_valid_i  in   NREQ    requester i presents a byte
//  req_data_i   in   8*NREQ  byte of requester i at [8i+7:8i]
//  req_last_i   in   NREQ    byte ends the message (releases the lock)
//  req_ready_o  out  NREQ    one-hot accept pulse; the byte is taken when valid&ready
//  rate_i       in   24      baud increment; 0 selects DEFAULT_RATE
//  uart_stb_o   out  1       UART bus strobe
//  uart_wea_o   out  1       UART write enable
//  uart_dat_o   out  32      {rate[23:0], byte[7:0]} during a write, else 0
//  uart_ack_i   in   1       UART ack (combinational copy of stb)
//  uart_dat_i   in   32      UART status; bit0 = busy
//  grant_o      out  NREQ    one-hot current owner (0 when no owner)
//  locked_o     out  1       a message is in progress
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; rr pointer = NREQ-1 (requester 0 wins first); lock clear.
//  FSM states: IDLE, POLL, WRITE, SETTLE.
//   IDLE: if locked, only the owner is eligible; else round-robin from ptr+1 over req_valid_i.
//    On a win: req_ready_o[w]=1 for exactly this cycle; latch byte, last flag, owner=w;
//    ptr<=w; go to POLL. If there is no winner, stay in IDLE.
//   POLL: stb=1, wea=0. If ack & ~uart_dat_i[0], go to WRITE; else stay.
//   WRITE: stb=1, wea=1, dat={rate_eff, byte}, for one cycle; rate_eff is sampled here.
//    Requires ack; holds while ack is low. Then go to SETTLE.
//   SETTLE: one cycle with stb=0, because UART busy is registered and rises the cycle after the write.
//    Then go to IDLE.
//  Lock: set when an accepted byte has last=0; cleared when an accepted byte has last=1.
//   In IDLE, while locked and the owner is not valid, a counter increments.
//   When counter==LOCK_TIMEOUT, the lock clears. The counter clears on any accept and on reset.
//  Throughput: at most one byte per 4 cycles, and in practice limited by the UART (11 bit times).
//  Single valid requester: it wins on each IDLE visit. Simultaneous requests: rr order, no starvation
//   when unlocked. Requester valid may drop at any time without an accept; nothing is taken.
//  Requester dropping valid during a lock: it is still owner until last or timeout.
//  Never writes while busy=1, so no byte is silently dropped by the UART.
//  Reset mid-message: the FSM, lock and pointer return to reset values. The latched byte is discarded.
//   The UART shares the reset, so its line returns idle-high.
//  Rate arithmetic: 24-bit, no saturation; rate_i changes take effect on the next WRITE only.
// STRUCTURE
//  uart_sched_pkg: state enum (2 bits), UART_BUSY_BIT=0, UART_RATE_LSB=8,
//   uart_word(rate,byte) packing function.
//  Sub-module rr_arbiter #(N): req, ptr, mask_en/mask -> one-hot grant + index; purely combinational.
//  Top: FSM, data/last latch, lock and timeout counter, bus drive.
// TESTING
//  1. Reset, then req0 sends 8'h41 with last=1, rate_i=0.
//     -> ready0 one cycle; one write with dat=32'h0000C941; the UART line shows 'A' at DEFAULT_RATE.
//  2. req0 and req1 both valid with last=1, each sending 3 bytes.
//     -> accepts alternate 0,1,0,1,0,1; ptr wraps correctly.
//  3. req0 sends "AB\n" (last on '\n') while req1 is constantly valid.
//     -> A, B, \n are sent contiguously; req1 is accepted only after \n.
//  4. req0 is locked (last=0), then drops valid; req1 is valid.
//     -> no accept for LOCK_TIMEOUT cycles, then req1 is granted; locked_o falls.
//  5. Force uart_dat_i[0]=1 for 50 cycles during POLL.
//     -> stb=1, wea=0 is held and no write occurs; write happens the cycle after busy=0.
//  6. Assert sys_rst_i during WRITE, and again while locked.
//     -> next cycle all outputs 0, state IDLE, grant 0; requester 0 wins the next arbitration.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the FSM state encoding and the packing of a UART bus write word.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    WRITE,
    SETTLE
  } state_t;

  localparam int UART_BUSY_BIT = 0;
  localparam int UART_RATE_LSB = 8;

  // Write word layout seen by the UART: baud increment above the data byte.
  function automatic logic [31:0] uart_word(input logic [23:0] rate, input logic [7:0] data);
    return ({8'h00, rate} << UART_RATE_LSB) | {24'h000000, data};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping,
// over the requests optionally restricted by a mask.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mask_en,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  eligible;
  logic [IW-1:0] pos;

  assign eligible = mask_en ? (req & mask) : req;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any && eligible[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NREQ byte-stream requesters with
// round-robin arbitration and a per-message lock so lines never interleave.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          NREQ         = 2,
  parameter logic [23:0] DEFAULT_RATE = 24'h00C9,
  parameter int          LOCK_TIMEOUT = 1023
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [23:0]       rate_i,
  output logic              uart_stb_o,
  output logic              uart_wea_o,
  output logic [31:0]       uart_dat_o,
  input  logic              uart_ack_i,
  input  logic [31:0]       uart_dat_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              locked_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  state_t        state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] owner_reg;
  logic [7:0]    byte_reg;
  logic          lock_reg;
  logic [CW-1:0] cnt_reg;

  logic [7:0]      req_bytes [NREQ];
  logic [NREQ-1:0] owner_hot;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            win;
  logic            owner_valid;
  logic [23:0]     rate_eff;
  logic            busy;
  logic            status_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data_i[8*gi +: 8];
      assign owner_hot[gi] = (owner_reg == IW'(gi));
    end
  endgenerate

  // While locked, only the message owner may be granted.
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req     (req_valid_i),
    .ptr     (ptr_reg),
    .mask_en (lock_reg),
    .mask    (owner_hot),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  assign busy          = uart_dat_i[UART_BUSY_BIT];
  assign status_unused = ^uart_dat_i[31:1];
  assign win           = (state_reg == IDLE) && arb_any && !sys_rst_i;
  assign owner_valid   = (state_reg != IDLE) || lock_reg;
  assign rate_eff      = (rate_i == 24'd0) ? DEFAULT_RATE : rate_i;

  assign req_ready_o = win ? arb_grant : '0;
  assign grant_o     = owner_valid ? owner_hot : '0;
  assign locked_o    = lock_reg;
  assign uart_stb_o  = (state_reg == POLL) || (state_reg == WRITE);
  assign uart_wea_o  = (state_reg == WRITE);
  assign uart_dat_o  = (state_reg == WRITE) ? uart_word(rate_eff, byte_reg) : 32'd0;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= IW'(NREQ - 1);
      owner_reg <= '0;
      byte_reg  <= '0;
      lock_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win) begin
            byte_reg  <= req_bytes[arb_idx];
            owner_reg <= arb_idx;
            ptr_reg   <= arb_idx;
            lock_reg  <= !req_last_i[arb_idx];
            cnt_reg   <= '0;
            state_reg <= POLL;
          end else if (lock_reg && !req_valid_i[owner_reg]) begin
            // An owner that goes quiet mid-message must not block the UART forever.
            if (cnt_reg == CW'(LOCK_TIMEOUT)) begin
              lock_reg <= 1'b0;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        POLL: begin
          if (uart_ack_i && !busy) state_reg <= WRITE;
        end
        WRITE: begin
          if (uart_ack_i) state_reg <= SETTLE;
        end
        SETTLE: begin
          // UART busy is registered; give it a cycle to rise before polling again.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-driven requesters, a
// registered-busy UART model and a scoreboard of expected write words.
module tb_uart_tx_scheduler;

  localparam int          NREQ     = 2;
  localparam int          LT       = 1023;
  localparam logic [23:0] DEF_RATE = 24'h00C9;
  localparam int          BUSY_LEN = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [23:0] rate;
  logic        stb;
  logic        wea;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic [1:0]  grant;
  logic        locked;

  logic force_busy;
  logic ack_block;
  int   busy_cnt;
  logic wr_now;
  logic wr_d;

  int          checks;
  int          errors;
  int          cyc;
  int          ready_cycles;
  int          wr_count;
  logic [31:0] last_word;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [31:0] sb[$];
  int          acc_ids[$];
  int          acc_cyc[$];

  uart_tx_scheduler #(
    .NREQ         (NREQ),
    .DEFAULT_RATE (DEF_RATE),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .rate_i      (rate),
    .uart_stb_o  (stb),
    .uart_wea_o  (wea),
    .uart_dat_o  (dat_o),
    .uart_ack_i  (ack),
    .uart_dat_i  (dat_i),
    .grant_o     (grant),
    .locked_o    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ack   = stb & ~ack_block;
  assign dat_i = {31'd0, (busy_cnt != 0) | force_busy};

  // UART model: busy rises one cycle after the write edge, then counts down.
  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
      wr_d     <= 1'b0;
    end else begin
      wr_d <= wr_now;
      if (wr_d) busy_cnt <= BUSY_LEN;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end

  function automatic logic [31:0] exp_word(input logic [23:0] r, input logic [7:0] b);
    return {((r == 24'd0) ? DEF_RATE : r), b};
  endfunction

  // Requester drivers: present queue heads on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        req_valid[0] = 1'b1; req_data[7:0] = q0[0][7:0]; req_last[0] = q0[0][8];
      end else begin
        req_valid[0] = 1'b0; req_data[7:0] = 8'h00; req_last[0] = 1'b0;
      end
      if (q1.size() != 0) begin
        req_valid[1] = 1'b1; req_data[15:8] = q1[0][7:0]; req_last[1] = q1[0][8];
      end else begin
        req_valid[1] = 1'b0; req_data[15:8] = 8'h00; req_last[1] = 1'b0;
      end
    end
  end

  // Monitor just before each rising edge: accepts feed the scoreboard, writes drain it.
  initial begin
    logic [31:0] e;
    wr_now = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (req_ready != 2'b00) begin
        ready_cycles++;
        checks++;
        if ($countones(req_ready) != 1) begin
          errors++;
          $display("FAIL ready_onehot got %b want one-hot", req_ready);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_ids.push_back(i);
          acc_cyc.push_back(cyc);
          if (i == 0) begin
            sb.push_back(exp_word(rate, q0[0][7:0]));
            $display("accept req0 byte=%h last=%b cycle=%0d", q0[0][7:0], q0[0][8], cyc);
            void'(q0.pop_front());
          end else begin
            sb.push_back(exp_word(rate, q1[0][7:0]));
            $display("accept req1 byte=%h last=%b cycle=%0d", q1[0][7:0], q1[0][8], cyc);
            void'(q1.pop_front());
          end
        end
      end
      wr_now = stb && wea && ack;
      if (wr_now) begin
        wr_count++;
        last_word = dat_o;
        $display("write dat=%h cycle=%0d", dat_o, cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %h want no write", dat_o);
        end else begin
          e = sb.pop_front();
          if (dat_o !== e) begin
            errors++;
            $display("FAIL write_word got %h want %h", dat_o, e);
          end
        end
        checks++;
        if (dat_i[0] !== 1'b0) begin
          errors++;
          $display("FAIL write_while_busy got busy=%b want 0", dat_i[0]);
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_ids.delete();
    acc_cyc.delete();
    ready_cycles = 0;
    wr_count     = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && stb == 1'b0) && n < budget) begin
      sample();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain got timeout after %0d cycles want idle", name, n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sample();
    checks++; if (stb !== 1'b0)      begin errors++; $display("FAIL reset_stb got %b want 0", stb); end
    checks++; if (wea !== 1'b0)      begin errors++; $display("FAIL reset_wea got %b want 0", wea); end
    checks++; if (dat_o !== 32'd0)   begin errors++; $display("FAIL reset_dat got %h want 0", dat_o); end
    checks++; if (grant !== 2'b00)   begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rate = 24'd0;
    q0.push_back({1'b1, 8'h41});
    wait_drain("single", 200);
    checks++; if (acc_ids.size() != 1) begin errors++; $display("FAIL single_accepts got %0d want 1", acc_ids.size()); end
    checks++; if (ready_cycles != 1)   begin errors++; $display("FAIL single_ready_cycles got %0d want 1", ready_cycles); end
    checks++; if (wr_count != 1)       begin errors++; $display("FAIL single_writes got %0d want 1", wr_count); end
    checks++; if (last_word !== 32'h0000C941) begin errors++; $display("FAIL single_word got %h want 0000c941", last_word); end
  endtask

  task automatic test_alternate();
    int exp_ord[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    rate = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'h61 + 8'(i)});
      q1.push_back({1'b1, 8'h71 + 8'(i)});
    end
    wait_drain("alternate", 500);
    checks++;
    if (acc_ids.size() != 6) begin
      errors++; $display("FAIL alt_count got %0d want 6", acc_ids.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_ids[i] != exp_ord[i]) begin
          errors++; $display("FAIL alt_order[%0d] got req%0d want req%0d", i, acc_ids[i], exp_ord[i]);
        end
      end
    end
    checks++; if (wr_count != 6) begin errors++; $display("FAIL alt_writes got %0d want 6", wr_count); end
  endtask

  task automatic test_lock_msg();
    int exp_ord[5] = '{0, 0, 0, 1, 1};
    do_reset();
    rate = 24'h000321;
    q1.push_back({1'b1, 8'h78});
    q1.push_back({1'b1, 8'h79});
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h0A});
    wait_drain("lock_msg", 500);
    checks++;
    if (acc_ids.size() != 5) begin
      errors++; $display("FAIL lock_count got %0d want 5", acc_ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acc_ids[i] != exp_ord[i]) begin
          errors++; $display("FAIL lock_order[%0d] got req%0d want req%0d", i, acc_ids[i], exp_ord[i]);
        end
      end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_end_locked got %b want 0", locked); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rate = 24'd0;
    q0.push_back({1'b0, 8'h4C});
    q1.push_back({1'b1, 8'h4D});
    n = 0;
    while (acc_ids.size() < 1 && n < 50) begin sample(); n++; end
    repeat (200) sample();
    checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL to_locked got %b want 1", locked); end
    checks++; if (grant !== 2'b01)    begin errors++; $display("FAIL to_grant_owner got %b want 01", grant); end
    checks++; if (acc_ids.size() != 1) begin errors++; $display("FAIL to_early_accept got %0d accepts want 1", acc_ids.size()); end
    n = 0;
    while (acc_ids.size() < 2 && n < LT + 100) begin sample(); n++; end
    checks++;
    if (acc_ids.size() < 2) begin
      errors++; $display("FAIL to_second_accept got none want req1");
    end else begin
      checks++;
      if (acc_ids[1] != 1) begin errors++; $display("FAIL to_winner got req%0d want req1", acc_ids[1]); end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != LT + 5) begin
        errors++; $display("FAIL to_gap got %0d want %0d", acc_cyc[1] - acc_cyc[0], LT + 5);
      end
    end
    sample();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_unlocked got %b want 0", locked); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_grant_new got %b want 10", grant); end
    wait_drain("timeout", 200);
  endtask

  task automatic test_busy();
    int n;
    int bad;
    do_reset();
    rate = 24'd0;
    force_busy = 1'b1;
    q0.push_back({1'b1, 8'h5A});
    n = 0;
    while (stb !== 1'b1 && n < 20) begin sample(); n++; end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (!(stb === 1'b1 && wea === 1'b0)) bad++;
    end
    checks++; if (bad != 0)      begin errors++; $display("FAIL busy_hold got %0d bad cycles want 0", bad); end
    checks++; if (wr_count != 0) begin errors++; $display("FAIL busy_no_write got %0d writes want 0", wr_count); end
    @(posedge clk); #1;
    force_busy = 1'b0;
    sample();
    checks++; if (wea !== 1'b0) begin errors++; $display("FAIL busy_release_poll got wea=%b want 0", wea); end
    sample();
    checks++; if (wea !== 1'b1) begin errors++; $display("FAIL busy_write_next got wea=%b want 1", wea); end
    wait_drain("busy", 100);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    rate = 24'd0;
    force_busy = 1'b1;
    q0.push_back({1'b1, 8'h51});
    n = 0;
    while (stb !== 1'b1 && n < 20) begin sample(); n++; end
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ack_block = 1'b1;
    sample();
    checks++; if (wea !== 1'b1) begin errors++; $display("FAIL mid_in_write got wea=%b want 1", wea); end
    @(posedge clk); #1;
    sample();
    checks++; if (stb !== 1'b0)    begin errors++; $display("FAIL mid_stb got %b want 0", stb); end
    checks++; if (wea !== 1'b0)    begin errors++; $display("FAIL mid_wea got %b want 0", wea); end
    checks++; if (dat_o !== 32'd0) begin errors++; $display("FAIL mid_dat got %h want 0", dat_o); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant got %b want 00", grant); end
    checks++; if (wr_count != 0)   begin errors++; $display("FAIL mid_no_write got %0d want 0", wr_count); end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_block = 1'b0;

    q0.push_back({1'b0, 8'h52});
    n = 0;
    while (!(sb.size() == 0 && q0.size() == 0 && stb == 1'b0 && wr_count == 1) && n < 100) begin sample(); n++; end
    sample();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_lock_set got %b want 1", locked); end
    q1.push_back({1'b1, 8'h53});
    rst = 1'b1;
    q0.push_back({1'b1, 8'h54});
    @(posedge clk); #1;
    sample();
    checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL mid_lock_clear got %b want 0", locked); end
    checks++; if (grant !== 2'b00)     begin errors++; $display("FAIL mid_lock_grant got %b want 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready_in_reset got %b want 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    acc_ids.delete();
    acc_cyc.delete();
    wait_drain("mid", 300);
    checks++;
    if (acc_ids.size() != 2) begin
      errors++; $display("FAIL mid_after_count got %0d want 2", acc_ids.size());
    end else begin
      checks++; if (acc_ids[0] != 0) begin errors++; $display("FAIL mid_first_winner got req%0d want req0", acc_ids[0]); end
      checks++; if (acc_ids[1] != 1) begin errors++; $display("FAIL mid_second_winner got req%0d want req1", acc_ids[1]); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    rate         = 24'd0;
    force_busy   = 1'b0;
    ack_block    = 1'b0;
    req_valid    = 2'b00;
    req_data     = 16'h0000;
    req_last     = 2'b00;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    ready_cycles = 0;
    wr_count     = 0;
    last_word    = 32'd0;
    test_reset();
    test_single();
    test_alternate();
    test_lock_msg();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish before 1000000ns");
    $fatal(1);
  end

endmodule
